// File: rtl/status_conditioner.sv
// status_conditioner: cleans up the raw PowerGear board signals for the LED indicator.
// Each raw input is synchronized and debounced. Button presses open a fixed-length
// display window. Current-direction flags are qualified so that pos and neg are never
// high at the same time.

module status_conditioner #(
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_level,
    input  logic raw_button_n,
    input  logic raw_usb,
    input  logic raw_stat,
    input  logic raw_pos,
    input  logic raw_neg,
    output logic level,
    output logic button,
    output logic usb,
    output logic stat,
    output logic pos,
    output logic neg,
    output logic fault
);

    localparam int unsigned NCH = 6;
    localparam int unsigned CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Channel positions in the packed channel vectors
    localparam int unsigned CH_LEVEL = 0;
    localparam int unsigned CH_BTN   = 1;
    localparam int unsigned CH_USB   = 2;
    localparam int unsigned CH_STAT  = 3;
    localparam int unsigned CH_POS   = 4;
    localparam int unsigned CH_NEG   = 5;

    // The button pin is active-low: its synchronizer idles at 1 and is inverted afterwards
    localparam logic [NCH-1:0] SYNC_RST = 6'b000010;
    localparam logic [NCH-1:0] INV_MASK = 6'b000010;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0] s_vec;
    logic [NCH-1:0] deb_q, deb_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    logic           press;
    logic           button_q, button_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           pos_q, neg_q, fault_q;

    assign raw_vec = {raw_neg, raw_pos, raw_stat, raw_usb, raw_button_n, raw_level};

    // Two-flop synchronizer for every raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= raw_vec;
            sync2_q <= sync1_q;
        end
    end

    assign s_vec = sync2_q ^ INV_MASK;

    // Debounce: flip only after DEB_CYCLES consecutive disagreeing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s_vec[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s_vec[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounced values and their run-length counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A press is the edge on which the debounced button goes 0 -> 1
    assign press = deb_d[CH_BTN] & ~deb_q[CH_BTN];

    // Display window: a press (re)loads the countdown, even on the edge it would expire
    always_comb begin
        button_d = button_q;
        hold_d   = hold_q;
        if (press) begin
            button_d = 1'b1;
            hold_d   = HOLD_LAST;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end else begin
            button_d = 1'b0;
        end
    end

    // Window state plus registered current-direction qualification
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_q <= 1'b0;
            hold_q   <= '0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            button_q <= button_d;
            hold_q   <= hold_d;
            pos_q    <= deb_q[CH_POS] & ~deb_q[CH_NEG];
            neg_q    <= deb_q[CH_NEG] & ~deb_q[CH_POS];
            fault_q  <= deb_q[CH_POS] & deb_q[CH_NEG];
        end
    end

    assign level  = deb_q[CH_LEVEL];
    assign usb    = deb_q[CH_USB];
    assign stat   = deb_q[CH_STAT];
    assign button = button_q;
    assign pos    = pos_q;
    assign neg    = neg_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_status_conditioner.sv
// Self-checking bench for status_conditioner: a vector table, hand-timed corner sequences
// and a randomized run compared against a history-based reference model.

module tb_status_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned NREC = 48;

    // Output vector bit positions: {level, button, usb, stat, pos, neg, fault}
    localparam int B_LEVEL = 6;
    localparam int B_BTN   = 5;
    localparam int B_USB   = 4;
    localparam int B_STAT  = 3;
    localparam int B_POS   = 2;
    localparam int B_NEG   = 1;
    localparam int B_FAULT = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_level = 1'b0, raw_button_n = 1'b1, raw_usb = 1'b0;
    logic raw_stat = 1'b0, raw_pos = 1'b0, raw_neg = 1'b0;
    logic level, button, usb, stat, pos, neg, fault;

    int errors = 0;
    int checks = 0;
    int overlaps = 0;

    logic [6:0] rec [1:NREC];

    typedef struct packed {
        logic [5:0] raw;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [6];

    status_conditioner #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_level   (raw_level),
        .raw_button_n(raw_button_n),
        .raw_usb     (raw_usb),
        .raw_stat    (raw_stat),
        .raw_pos     (raw_pos),
        .raw_neg     (raw_neg),
        .level       (level),
        .button      (button),
        .usb         (usb),
        .stat        (stat),
        .pos         (pos),
        .neg         (neg),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // pos and neg must never be high together
    always @(negedge clk) begin
        if (pos && neg) overlaps++;
    end

    function automatic logic [6:0] outs();
        return {level, button, usb, stat, pos, neg, fault};
    endfunction

    // Raw packing: [0]=level [1]=button_n [2]=usb [3]=stat [4]=pos [5]=neg
    function automatic logic [5:0] mk(input logic l, input logic pressed, input logic u,
                                      input logic s, input logic p, input logic n);
        return {n, p, s, u, ~pressed, l};
    endfunction

    task automatic set_raw(input logic [5:0] r);
        {raw_neg, raw_pos, raw_stat, raw_usb, raw_button_n, raw_level} = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hold r for n ticks, recording outputs after each edge
    task automatic record(input logic [5:0] r, input int n);
        set_raw(r);
        for (int t = 1; t <= n; t++) begin
            tick();
            rec[t] = outs();
        end
    endtask

    function automatic int first_val(input int b, input logic v, input int n);
        for (int t = 1; t <= n; t++) begin
            if (rec[t][b] == v) return t;
        end
        return -1;
    endfunction

    function automatic int count_high(input int b, input int n);
        int c = 0;
        for (int t = 1; t <= n; t++) begin
            if (rec[t][b]) c++;
        end
        return c;
    endfunction

    function automatic int last_high(input int b, input int n);
        int l = -1;
        for (int t = 1; t <= n; t++) begin
            if (rec[t][b]) l = t;
        end
        return l;
    endfunction

    // Button scenario: pressed p1 ticks, released r ticks, pressed p2 ticks, then released
    task automatic btn_run(input string name, input int p1, input int r, input int p2,
                           input int exp_first, input int exp_highs, input int exp_lows);
        int first, highs, last;
        for (int t = 1; t <= int'(NREC); t++) begin
            set_raw(mk(0, (t <= p1) || (t > p1 + r && t <= p1 + r + p2), 0, 0, 0, 0));
            tick();
            rec[t] = outs();
        end
        first = first_val(B_BTN, 1'b1, NREC);
        highs = count_high(B_BTN, NREC);
        last  = last_high(B_BTN, NREC);
        check_int({name, "_first"}, first, exp_first);
        check_int({name, "_highs"}, highs, exp_highs);
        check_int({name, "_lows_inside"}, last - first + 1 - highs, exp_lows);
        set_raw('0 | 6'b000010);
        repeat (20) tick();
    endtask

    // Reference model: history of synchronized samples since reset
    logic [5:0] m_rq [$];
    logic [5:0] m_sh [$];
    logic [5:0] m_d;
    int         m_k;
    int         m_last_press;
    bit         m_have;

    task automatic model_reset();
        m_rq = '{6'b000010, 6'b000010};
        m_sh.delete();
        m_d = '0;
        m_k = 0;
        m_last_press = 0;
        m_have = 0;
    endtask

    // Expected outputs after the next edge, given the raw value sampled at that edge
    task automatic model_step(input logic [5:0] r, output logic [6:0] e);
        logic [5:0] s_cur;
        logic [5:0] nd;
        bit all_diff;
        m_k++;
        // The sample seen by the debouncer is the raw value from two edges back
        s_cur = m_rq[0] ^ 6'b000010;
        m_sh.push_back(s_cur);
        if (m_sh.size() > int'(DEB)) void'(m_sh.pop_front());
        nd = m_d;
        for (int ch = 0; ch < 6; ch++) begin
            if (m_sh.size() == int'(DEB)) begin
                all_diff = 1;
                for (int j = 0; j < m_sh.size(); j++) begin
                    if (m_sh[j][ch] == m_d[ch]) all_diff = 0;
                end
                if (all_diff) nd[ch] = ~m_d[ch];
            end
        end
        if (nd[1] && !m_d[1]) begin
            m_last_press = m_k;
            m_have = 1;
        end
        e = {nd[0], (m_have && (m_k - m_last_press < int'(HOLD))), nd[2], nd[3],
             m_d[4] & ~m_d[5], m_d[5] & ~m_d[4], m_d[4] & m_d[5]};
        m_d = nd;
        m_rq.push_back(r);
        void'(m_rq.pop_front());
    endtask

    initial begin
        logic [5:0] idle;
        logic [5:0] r;
        logic [6:0] e;
        int seen;

        idle = mk(0, 0, 0, 0, 0, 0);

        // Reset with every input active, then release
        set_raw(mk(1, 1, 1, 1, 1, 1));
        rst = 1'b1;
        tick();
        tick();
        check_vec("reset_outs", outs(), 7'b0);
        rst = 1'b0;
        record(mk(1, 1, 1, 1, 1, 1), 20);
        check_vec("reset_before_rise", rec[5], 7'b0000000);
        check_vec("reset_rise", rec[6], 7'b1111000);
        check_vec("reset_fault", rec[7], 7'b1111001);
        check_int("reset_btn_first", first_val(B_BTN, 1'b1, 20), 6);
        check_int("reset_btn_highs", count_high(B_BTN, 20), HOLD);
        check_vec("reset_window_end", rec[14], 7'b1011001);

        set_raw(idle);
        repeat (10) tick();
        check_vec("idle", outs(), 7'b0);

        // Steady-state vector table (button released throughout)
        tbl[0] = '{raw: mk(1, 0, 0, 0, 0, 0), exp: 7'b1000000};
        tbl[1] = '{raw: mk(0, 0, 1, 0, 1, 0), exp: 7'b0010100};
        tbl[2] = '{raw: mk(0, 0, 0, 1, 0, 1), exp: 7'b0001010};
        tbl[3] = '{raw: mk(1, 0, 1, 1, 1, 1), exp: 7'b1011001};
        tbl[4] = '{raw: mk(0, 0, 0, 0, 0, 0), exp: 7'b0000000};
        tbl[5] = '{raw: mk(1, 0, 0, 1, 1, 0), exp: 7'b1001100};
        for (int i = 0; i < 6; i++) begin
            set_raw(tbl[i].raw);
            repeat (10) tick();
            check_vec($sformatf("table_%0d", i), outs(), tbl[i].exp);
        end
        set_raw(idle);
        repeat (10) tick();

        // Glitch reject: 3-cycle usb pulse is discarded
        seen = 0;
        set_raw(mk(0, 0, 1, 0, 0, 0));
        repeat (3) begin
            tick();
            if (usb) seen++;
        end
        set_raw(idle);
        repeat (10) begin
            tick();
            if (usb) seen++;
        end
        check_int("glitch_3_usb_high", seen, 0);

        // 5-cycle pulse passes: rises at t=6, falls five edges after the pulse ends
        set_raw(mk(0, 0, 1, 0, 0, 0));
        for (int t = 1; t <= 15; t++) begin
            if (t == 6) set_raw(idle);
            tick();
            rec[t] = outs();
        end
        check_int("pulse_5_rise", first_val(B_USB, 1'b1, 15), 6);
        check_int("pulse_5_last_high", last_high(B_USB, 15), 10);
        repeat (5) tick();

        // Button window scenarios
        btn_run("btn_single", 10, 38, 0, 6, 8, 0);
        btn_run("btn_reload_boundary", 4, 4, 20, 6, 16, 0);
        btn_run("btn_gap_9", 4, 5, 20, 6, 16, 1);

        // Current exclusion
        set_raw(mk(0, 0, 0, 0, 1, 0));
        repeat (10) tick();
        check_vec("cur_pos_only", outs(), 7'b0000100);
        record(mk(0, 0, 0, 0, 1, 1), 12);
        check_int("cur_pos_drop", first_val(B_POS, 1'b0, 12), 7);
        check_int("cur_fault_rise", first_val(B_FAULT, 1'b1, 12), 7);
        record(mk(0, 0, 0, 0, 0, 1), 12);
        check_int("cur_neg_rise", first_val(B_NEG, 1'b1, 12), 7);
        check_int("cur_fault_drop", first_val(B_FAULT, 1'b0, 12), 7);
        record(mk(0, 0, 0, 0, 1, 0), 12);
        check_vec("cross_before", {5'b0, rec[6][B_POS], rec[6][B_NEG]}, 7'b0000001);
        check_vec("cross_after", {5'b0, rec[7][B_POS], rec[7][B_NEG]}, 7'b0000010);
        set_raw(idle);
        repeat (10) tick();

        // Async reset three cycles into a window while stat is mid-debounce
        for (int t = 1; t <= 9; t++) begin
            set_raw(mk(0, 1, 0, (t >= 7), 0, 0));
            tick();
        end
        check_int("pre_reset_button", int'(button), 1);
        #2;
        rst = 1'b1;
        #1;
        check_vec("async_reset_outs", outs(), 7'b0);
        tick();
        tick();
        rst = 1'b0;
        record(mk(0, 1, 0, 1, 0, 0), 20);
        check_vec("rerst_before_rise", rec[5], 7'b0000000);
        check_vec("rerst_rise", rec[6], 7'b0101000);
        check_int("rerst_btn_highs", count_high(B_BTN, 20), HOLD);
        set_raw(idle);
        repeat (10) tick();

        // Randomized run against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        r = idle;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            set_raw(r);
            model_step(r, e);
            tick();
            check_vec($sformatf("random_cycle_%0d", c), outs(), e);
        end

        check_int("pos_neg_overlap_cycles", overlaps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/status_conditioner.md
# status_conditioner

Front-end for the PowerGear LED indicator. Takes raw, asynchronous board signals and produces the clean, stable status levels the indicator logic consumes: battery level, button, USB present, charger stat, positive and negative current. The raw signals are the button pin, USB detect, charger STAT, level comparator and current-sense comparators. It synchronizes, debounces and qualifies each input, stretches button presses into a fixed display window, and blanks contradictory current-direction readings.

## Interface

Parameters:
- DEB_CYCLES, 16: consecutive cycles a synchronized input must differ from its debounced value before the debounced value flips; legal range ≥ 2.
- HOLD_CYCLES, 1024: length in cycles of the button display window; legal range ≥ 1.

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- raw_level  in  1  battery-level comparator, async, active-high
- raw_button_n  in  1  push-button pin, async, active-low
- raw_usb  in  1  USB VBUS detect, async, active-high
- raw_stat  in  1  charger STAT pin, async, active-high
- raw_pos  in  1  charge-current comparator, async, active-high
- raw_neg  in  1  discharge-current comparator, async, active-high
- level  out  1  debounced battery-level status
- button  out  1  display-window request, high for HOLD_CYCLES after a press
- usb  out  1  debounced USB present
- stat  out  1  debounced charger STAT
- pos  out  1  qualified charge-current flag
- neg  out  1  qualified discharge-current flag
- fault  out  1  pos and neg comparators both debounced high

## Operation

- **Synchronizer:** every raw input passes through a 2-flop synchronizer. raw_button_n is inverted after synchronization, giving s_btn (1 = pressed). Synchronizer flops reset to 0, except the raw_button_n chain, which resets to 1 (released).
- **Debouncer:** one per channel (level, btn, usb, stat, pos, neg). Each has a debounced register d_x and a counter cnt_x of width $clog2(DEB_CYCLES). Per edge:
  - If s_x == d_x: cnt_x ← 0.
  - Else, if cnt_x == DEB_CYCLES-1: d_x ← s_x and cnt_x ← 0.
  - Else: cnt_x ← cnt_x+1.
  - Any glitch shorter than DEB_CYCLES synchronized cycles is discarded.
- **Direct outputs:** level, usb and stat are driven directly from d_level, d_usb and d_stat.
- **Button window:** a press event is the edge at which d_btn flips 0→1. On a press event, button ← 1 and hold_cnt ← HOLD_CYCLES-1.
  - Otherwise, if hold_cnt ≠ 0: hold_cnt ← hold_cnt-1.
  - Otherwise: button ← 0.
  - A new press during the window reloads hold_cnt, which extends the window.
  - Release (d_btn 1→0) has no effect on the window.
  - Holding the button longer than the window does not extend it.
- **Current qualification:** registered, one cycle after the d_pos/d_neg update.
  - pos ← d_pos & ~d_neg
  - neg ← d_neg & ~d_pos
  - fault ← d_pos & d_neg
  - pos and neg are never 1 simultaneously.

## Timing

- **Reset:** asynchronous assert clears all outputs (level, button, usb, stat, pos, neg, fault = 0), all d_x (d_btn = 0), all counters and hold_cnt. Outputs are valid on the first edge after deassertion, with no spurious press event after reset.
- **level/usb/stat latency:** a raw change stable before edge N appears on the output at edge N+DEB_CYCLES+1. That is 2 synchronizer edges, then DEB_CYCLES debounce edges, the last of which overlaps the final synchronizer edge count, giving N+1+DEB_CYCLES.
- **button latency:** same as level/usb/stat; button rises on the same edge as d_btn.
- **pos/neg/fault latency:** one edge more than level/usb/stat.
- **Button window length:** button stays high for exactly HOLD_CYCLES cycles after a single press.
- **Simultaneous events:** a press event on the same edge that hold_cnt reaches 0 reloads the window; button does not drop.
- **pos/neg cross-over:** if d_pos and d_neg flip on the same edge (pos→0, neg→1), outputs swap on the next edge with no overlap cycle.
- **Reset mid-window or mid-debounce:** everything returns to reset values immediately; a button still held at deassertion is debounced from d_btn = 0 and produces a fresh press event.

## Test plan

Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=8.

- **Reset:** assert rst with all raw inputs high and raw_button_n=0 → all outputs 0 during reset. After release, button rises 6 edges later and holds for 8 cycles; usb, stat and level rise 6 edges after release; pos and neg stay 0, fault rises 7 edges after release.
- **Glitch reject:** raw_usb pulses high for 3 cycles → usb stays 0. A 5-cycle pulse → usb rises at edge N+5 and falls 5 edges after the pulse ends.
- **Button window:** a single 10-cycle press → button high for exactly 8 cycles starting at press+5. A second press whose event lands 3 cycles into the window → button stays high 8 cycles after the second event (11 total).
- **Window boundary:** a press event timed on the edge where hold_cnt=0 → button has no low cycle.
- **Current exclusion:** raw_pos=1 steady, then raw_neg=1 → pos drops and fault rises on the same edge. Then raw_pos=0 → fault drops and neg rises on the same edge; pos and neg are never both 1.
- **Async reset mid-operation:** assert rst 3 cycles into a button window and mid-debounce on raw_stat → all outputs 0 within the reset cycle. After release, behaviour matches the fresh-reset case.
